// File: rtl/i2d_opmux_fwd_if.sv
// i2d_opmux_fwd_if: decode-to-execute operand request/response bundle
// master: decode/execute side (drives request, fwd_*, out_ready, flush)
// slave:  operand-select stage (drives in_ready, out_valid, a, b)
// I2D_OPMUX_SWAP_EN adds the swap request bit.
interface i2d_opmux_fwd_if #(parameter int DW = 32, parameter int AW = 5, parameter int NFWD = 2);
  logic flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] ra, rb, id_pc, imm, a, b;
  logic [AW-1:0] ra_idx, rb_idx;
  logic [1:0] sel_a, sel_b;
  logic [NFWD-1:0] fwd_valid;
  logic [NFWD*AW-1:0] fwd_idx;
  logic [NFWD*DW-1:0] fwd_data;
`ifdef I2D_OPMUX_SWAP_EN
  logic swap;
`endif
  modport master (
`ifdef I2D_OPMUX_SWAP_EN
    output swap,
`endif
    output flush, in_valid, ra, rb, ra_idx, rb_idx, id_pc, imm, sel_a, sel_b,
    output fwd_valid, fwd_idx, fwd_data, out_ready,
    input in_ready, out_valid, a, b
  );
  modport slave (
`ifdef I2D_OPMUX_SWAP_EN
    input swap,
`endif
    input flush, in_valid, ra, rb, ra_idx, rb_idx, id_pc, imm, sel_a, sel_b,
    input fwd_valid, fwd_idx, fwd_data, out_ready,
    output in_ready, out_valid, a, b
  );
endinterface

// File: rtl/i2d_opmux_fwd.sv
// i2d_opmux_fwd: operand select with bypass forwarding and a registered valid/ready output stage
// Ports: clk, rst (sync, active-high); bus (i2d_opmux_fwd_if.slave) carries
//   request (in_valid/in_ready, ra/rb, ra_idx/rb_idx, id_pc, imm, sel_a/sel_b),
//   bypass (fwd_valid/fwd_idx/fwd_data), flush, and output (out_valid/out_ready, a, b).
// Optional: I2D_OPMUX_SWAP_EN adds bus.swap to exchange A/B on load.
module i2d_opmux_fwd #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NFWD = 2
) (
  input logic clk,
  input logic rst,
  i2d_opmux_fwd_if.slave bus
);
  logic [DW-1:0] fa, fb, mux_a, mux_b, nxt_a, nxt_b, a_q, b_q;
  logic v_q, load;
  // Walk channels oldest to youngest so the lowest matching index wins.
  always_comb begin
    fa = bus.ra;
    fb = bus.rb;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (bus.fwd_valid[k] && bus.ra_idx != '0 && bus.fwd_idx[k*AW +: AW] == bus.ra_idx) fa = bus.fwd_data[k*DW +: DW];
      if (bus.fwd_valid[k] && bus.rb_idx != '0 && bus.fwd_idx[k*AW +: AW] == bus.rb_idx) fb = bus.fwd_data[k*DW +: DW];
    end
  end
  assign mux_a = bus.sel_a == 2'd0 ? fa : bus.sel_a == 2'd1 ? bus.id_pc : '0;
  assign mux_b = bus.sel_b == 2'd0 ? fb : bus.sel_b == 2'd1 ? bus.id_pc : bus.sel_b == 2'd2 ? bus.imm : '0;
`ifdef I2D_OPMUX_SWAP_EN
  assign nxt_a = bus.swap ? mux_b : mux_a;
  assign nxt_b = bus.swap ? mux_a : mux_b;
`else
  assign nxt_a = mux_a;
  assign nxt_b = mux_b;
`endif
  assign bus.in_ready = ~v_q | bus.out_ready;
  assign load = bus.in_valid & bus.in_ready & ~bus.flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else if (bus.flush) begin
      v_q <= 1'b0;
    end else if (load) begin
      v_q <= 1'b1;
      a_q <= nxt_a;
      b_q <= nxt_b;
    end else if (bus.out_ready) begin
      v_q <= 1'b0;
    end
  end
  assign bus.out_valid = v_q;
  assign bus.a = a_q;
  assign bus.b = b_q;
endmodule

// File: tb/tb_i2d_opmux_fwd.sv
// tb_i2d_opmux_fwd: directed bench with a cycle-level reference model of the operand stage
module tb_i2d_opmux_fwd;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NFWD = 2;
  logic clk = 1'b0;
  logic rst;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic chk_en = 1'b0;
  i2d_opmux_fwd_if #(.DW(DW), .AW(AW), .NFWD(NFWD)) bus ();
  i2d_opmux_fwd #(.DW(DW), .AW(AW), .NFWD(NFWD)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic m_v;
  logic [DW-1:0] m_a, m_b;
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  // Register operand value as execute must see it: first live bypass channel naming the index, else the file.
  function automatic logic [DW-1:0] reg_val(input logic [AW-1:0] idx, input logic [DW-1:0] rf);
    if (idx == 0) return rf;
    for (int k = 0; k < NFWD; k++)
      if (bus.fwd_valid[k] && bus.fwd_idx[k*AW +: AW] == idx) return bus.fwd_data[k*DW +: DW];
    return rf;
  endfunction
  function automatic logic [DW-1:0] want_a();
    case (bus.sel_a)
      2'd0: return reg_val(bus.ra_idx, bus.ra);
      2'd1: return bus.id_pc;
      default: return 0;
    endcase
  endfunction
  function automatic logic [DW-1:0] want_b();
    case (bus.sel_b)
      2'd0: return reg_val(bus.rb_idx, bus.rb);
      2'd1: return bus.id_pc;
      2'd2: return bus.imm;
      default: return 0;
    endcase
  endfunction
  always @(posedge clk) begin
    logic take, sw;
    take = bus.in_valid && (!m_v || bus.out_ready) && !bus.flush;
    sw = 1'b0;
`ifdef I2D_OPMUX_SWAP_EN
    sw = bus.swap;
`endif
    if (rst) begin
      m_v <= 1'b0; m_a <= 0; m_b <= 0;
    end else if (take) begin
      m_v <= 1'b1;
      m_a <= sw ? want_b() : want_a();
      m_b <= sw ? want_a() : want_b();
    end else if (bus.flush || bus.out_ready) begin
      m_v <= 1'b0;
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("model out_valid", {31'd0, bus.out_valid}, {31'd0, m_v});
    chk("model in_ready", {31'd0, bus.in_ready}, {31'd0, !m_v || bus.out_ready});
    chk("model a", bus.a, m_a);
    chk("model b", bus.b, m_b);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.flush = 0; bus.in_valid = 1; bus.out_ready = 1;
    bus.ra = 32'h11; bus.rb = 0; bus.ra_idx = 0; bus.rb_idx = 0;
    bus.id_pc = 0; bus.imm = 0; bus.sel_a = 0; bus.sel_b = 0;
    bus.fwd_valid = 0; bus.fwd_idx = 0; bus.fwd_data = 0;
`ifdef I2D_OPMUX_SWAP_EN
    bus.swap = 0;
`endif
    step();
    chk_en = 1'b1;
    step();
    chk("reset a", bus.a, 0);
    chk("reset b", bus.b, 0);
    chk("reset out_valid", {31'd0, bus.out_valid}, 0);
    rst = 1'b0; bus.in_valid = 0;
    #1 chk("post-reset in_ready", {31'd0, bus.in_ready}, 1);
    bus.sel_a = 1; bus.id_pc = 32'h1000; bus.sel_b = 2; bus.imm = 32'hFFFFFFF0; bus.in_valid = 1;
    step();
    chk("pc/imm a", bus.a, 32'h1000);
    chk("pc/imm b", bus.b, 32'hFFFFFFF0);
    chk("pc/imm out_valid", {31'd0, bus.out_valid}, 1);
    bus.sel_a = 0; bus.sel_b = 0; bus.ra_idx = 3; bus.rb_idx = 3; bus.ra = 5; bus.rb = 5;
    bus.fwd_valid = 2'b11; bus.fwd_idx = {5'd3, 5'd3}; bus.fwd_data = {32'hBB, 32'hAA};
    step();
    chk("fwd prio a", bus.a, 32'hAA);
    chk("fwd prio b", bus.b, 32'hAA);
    bus.ra_idx = 0;
    step();
    chk("idx0 a", bus.a, 32'h5);
    chk("idx0 b", bus.b, 32'hAA);
    bus.ra_idx = 3; bus.rb_idx = 4; bus.fwd_idx = {5'd3, 5'd4};
    step();
    chk("fwd ch1 a", bus.a, 32'hBB);
    chk("fwd ch0 b", bus.b, 32'hAA);
    bus.fwd_valid = 2'b01; bus.rb_idx = 7; bus.rb = 32'h77;
    step();
    chk("fwd invalid a", bus.a, 32'h5);
    chk("no match b", bus.b, 32'h77);
    bus.sel_a = 2; bus.sel_b = 3;
    step();
    chk("reserved a", bus.a, 0);
    chk("reserved b", bus.b, 0);
    bus.sel_a = 3; bus.sel_b = 1; bus.id_pc = 32'h2468;
    step();
    chk("reserved3 a", bus.a, 0);
    chk("pc b", bus.b, 32'h2468);
    bus.sel_a = 0; bus.sel_b = 0; bus.fwd_valid = 0;
    bus.ra_idx = 1; bus.rb_idx = 2; bus.ra = 1; bus.rb = 2;
    step();
    chk("stall load a", bus.a, 1);
    chk("stall load b", bus.b, 2);
    bus.out_ready = 0; bus.ra = 9; bus.rb = 9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall a", bus.a, 1);
      chk("stall b", bus.b, 2);
      chk("stall in_ready", {31'd0, bus.in_ready}, 0);
    end
    bus.out_ready = 1;
    #1 chk("release in_ready", {31'd0, bus.in_ready}, 1);
    step();
    chk("release a", bus.a, 9);
    chk("release b", bus.b, 9);
    bus.ra = 32'h33; bus.flush = 1;
    step();
    chk("flush out_valid", {31'd0, bus.out_valid}, 0);
    chk("flush a", bus.a, 9);
    chk("flush b", bus.b, 9);
    bus.flush = 0; bus.ra = 7; bus.imm = 3; bus.sel_b = 2;
`ifdef I2D_OPMUX_SWAP_EN
    bus.swap = 1;
    step();
    chk("swap a", bus.a, 3);
    chk("swap b", bus.b, 7);
    bus.swap = 0;
`else
    step();
    chk("noswap a", bus.a, 7);
    chk("noswap b", bus.b, 3);
`endif
    bus.in_valid = 0;
    step();
    chk("drain out_valid", {31'd0, bus.out_valid}, 0);
    bus.out_ready = 0;
    #1 chk("idle in_ready", {31'd0, bus.in_ready}, 1);
    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/i2d_opmux_fwd.md
Name: i2d_opmux_fwd

Overview:
- Parametrised operand-select stage between decode and execute.
- Selects operands A and B from register-file read data, decode PC or immediate.
- Overrides register operands with in-flight results through NFWD bypass channels.
- Registers A and B in an output stage with a valid/ready handshake, stall hold and flush.

Parameters:
DW, 32, operand/data width in bits
AW, 5, register index width
NFWD, 2, number of bypass channels; channel 0 has highest priority (youngest producer)

Ports:
clk  input  1  clock; single clock domain; one clock; reset is synchronous and active-high
rst  input  1  synchronous active-high reset
flush  input  1  discard held operand pair and any load in the same cycle
in_valid  input  1  decode presents a valid operand request
in_ready  output  1  stage can accept a request this cycle
ra  input  DW  register-file read data, port A
rb  input  DW  register-file read data, port B
ra_idx  input  AW  register index behind ra
rb_idx  input  AW  register index behind rb
id_pc  input  DW  PC of the decoding instruction
imm  input  DW  decoded immediate
sel_a  input  2  A select: 0=RA, 1=ID_PC, 2/3=zero
sel_b  input  2  B select: 0=RB, 1=ID_PC, 2=IMM, 3=zero
fwd_valid  input  NFWD  bypass channel k carries a result
fwd_idx  input  NFWD*AW  destination index of channel k, at bits [k*AW +: AW]
fwd_data  input  NFWD*DW  result of channel k, at bits [k*DW +: DW]
out_valid  output  1  a/b hold a valid operand pair
out_ready  input  1  execute consumes the pair this cycle
a  output  DW  registered operand A
b  output  DW  registered operand B

Behaviour:
- Reset (rst=1 at a clk edge): a=0, b=0, out_valid=0. rst overrides flush and load. in_ready=1 in the cycle after reset.
- Handshake:
  - in_ready = ~out_valid | out_ready. This is combinational and does not depend on in_valid.
  - load = in_valid & in_ready & ~flush.
- Register update priority, at each clk edge:
  - rst clears the stage.
  - Otherwise flush: out_valid<=0, a/b unchanged.
  - Otherwise load: a/b take the muxed values and out_valid<=1.
  - Otherwise, if out_ready: out_valid<=0.
  - Otherwise: hold.
- Latency: one cycle from an accepted request to out_valid.
- Throughput: one pair per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, a and b stay bit-stable and in_ready=0.
- Mux and forwarding (combinational, sampled at the load edge):
  - For a register-sourced operand (sel_a=0 or sel_b=0), with index i = ra_idx or rb_idx: if i!=0 and any k has fwd_valid[k]=1 and fwd_idx[k]==i, the lowest such k supplies fwd_data[k]. Otherwise ra/rb is used.
  - Index 0 is never forwarded (hardwired zero register). Its value is whatever ra/rb carries.
  - ID_PC, IMM and zero selects are never forwarded.
  - The mux is fully sensitive to all data inputs. A change on ra/rb/imm/id_pc/fwd_* without a select change still propagates.
- Both operands may forward from the same channel in the same cycle.
- Reserved select codes (sel_a=2/3, sel_b=3) give zero. They are not errors.
- flush with load in the same cycle: load is dropped. in_ready still follows its formula, so decode sees acceptance and must treat it as squashed.

Optional Feature:
I2D_OPMUX_SWAP_EN
- Defined:
  - Adds input port swap (1 bit).
  - On a load with swap=1, the post-forwarding A value is written to b and the B value to a.
  - swap is ignored when no load occurs.
- Undefined: no swap port exists and a/b are never exchanged. All other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles with in_valid=1, ra=0x11 -> a=0, b=0, out_valid=0. The cycle after rst drops: in_ready=1.
- sel_a=1, id_pc=0x1000, sel_b=2, imm=0xFFFFFFF0, in_valid=1, out_ready=1 -> next cycle a=0x1000, b=0xFFFFFFF0, out_valid=1.
- Forwarding, sel_a=0, sel_b=0, ra_idx=3, rb_idx=3, ra=rb=0x5:
  - fwd_valid=2'b11, fwd_idx={3,3}, fwd_data ch0=0xAA, ch1=0xBB -> a=b=0xAA (channel 0 wins).
  - Repeat with ra_idx=0 -> a=0x5.
- Stall: load 0x1/0x2, then out_ready=0 for 3 cycles while new inputs 0x9/0x9 are presented -> a/b stay 0x1/0x2, in_ready=0. out_ready=1 -> the pending request loads the following cycle.
- Flush with in_valid=1, out_valid=1 -> next cycle out_valid=0, a/b unchanged. With I2D_OPMUX_SWAP_EN and swap=1, ra=0x7, imm=0x3, sel_b=2 -> a=0x3, b=0x7.
